bcd_dabble_conv: RTL and testbench

//  Parametrised sequential binary-to-BCD converter (shift-and-add-3, one shift+adjust per clock).

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bcd_dabble_conv.sv | 171 +++++++++++++++++
 tb/tb_bcd_dabble_conv.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: digit width and
// type, converter FSM state encoding, saturation digit and a constant clog2 helper.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit value used for every position when the result does not fit.
  localparam bcd_digit_t SAT_DIGIT = 4'h9;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Per-digit "add 3" correction of the shift-and-add-3 algorithm. Applied to every
// digit before each left shift so that doubling a digit >= 5 carries correctly.
// Ports:
//   digit_i  in   4  BCD digit before correction
//   digit_o  out  4  digit_i + 3 when digit_i > 4, else digit_i
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  // Inputs never exceed 9, so the sum stays within 4 bits.
  assign digit_o = (digit_i > 4'd4) ? digit_i + 4'd3 : digit_i;

endmodule : bcd_digit_adj

// File: rtl/bcd_dabble_conv.sv
// Sequential binary-to-BCD converter (double dabble), one adjust+shift per clock.
// Accepts a value on a valid/ready handshake, converts its magnitude in DATA_W
// cycles, then presents registered digits, sign, overflow flag and a leading-zero
// blanking mask until the consumer takes the result.
// Ports:
//   sys_clk    in   1         clock
//   sys_rst_n  in   1         asynchronous active-low reset
//   in_valid   in   1         input value present
//   in_ready   out  1         converter idle and able to accept
//   data       in   DATA_W    binary value (two's complement when SIGNED=1)
//   out_valid  out  1         result present, held until out_ready
//   out_ready  in   1         consumer takes result
//   bcd        out  4*DIGITS  packed digits, units in [3:0]
//   sign       out  1         input was negative
//   ovf        out  1         value exceeded 10^DIGITS-1, bcd saturated to all 9s
//   nz_mask    out  DIGITS    bit i set when digit i should be displayed
module bcd_dabble_conv
  import bcd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      sign,
  output logic                      ovf,
  output logic [DIGITS-1:0]         nz_mask
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [ACC_W-1:0] SAT_ACC  = {DIGITS{SAT_DIGIT}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mag_q, mag_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic [DIGITS-1:0]  nz_q, nz_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               shift_out;
  logic               neg_in;
  logic               final_ovf;
  logic [ACC_W-1:0]   final_bcd;
  logic [DIGITS-1:0]  final_mask;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The magnitude MSB enters the units digit; the top digit's MSB leaves the
  // accumulator and flags a value too large for DIGITS digits.
  assign acc_shift = {acc_adj[ACC_W-2:0], mag_q[DATA_W-1]};
  assign shift_out = acc_adj[ACC_W-1];
  assign neg_in    = (SIGNED != 0) && data[DATA_W-1];

  // Result as it will look on the final CONV cycle.
  assign final_ovf = ovf_acc_q | shift_out;
  assign final_bcd = final_ovf ? SAT_ACC : acc_shift;

  // A digit is shown if it or any more significant digit is nonzero; units always shown.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    final_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen          = seen | (|final_bcd[i*DIGIT_W +: DIGIT_W]);
      final_mask[i] = seen;
    end
    final_mask[0] = 1'b1;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    nz_d      = nz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_CONV;
          // Negating -2^(W-1) gives 2^(W-1), which is exact as an unsigned magnitude.
          mag_d     = neg_in ? -data : data;
          neg_d     = neg_in;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_CONV: begin
        acc_d     = acc_shift;
        mag_d     = mag_q << 1;
        ovf_acc_d = final_ovf;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          bcd_d   = final_bcd;
          sign_d  = neg_q;
          ovf_d   = final_ovf;
          nz_d    = final_mask;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mag_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      nz_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      nz_q      <= nz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd       = bcd_q;
  assign sign      = sign_q;
  assign ovf       = ovf_q;
  assign nz_mask   = nz_q;

endmodule : bcd_dabble_conv

// File: tb/tb_bcd_dabble_conv.sv
// Directed bench for bcd_dabble_conv. Three instances share clock and reset:
//   unit 0: DATA_W=16, DIGITS=5, unsigned
//   unit 1: DATA_W=16, DIGITS=4, unsigned (overflow/saturation)
//   unit 2: DATA_W=8,  DIGITS=3, signed
module tb_bcd_dabble_conv;

  logic sys_clk;
  logic sys_rst_n;

  logic        in_valid_s  [3];
  logic        out_ready_s [3];
  logic [15:0] data_s      [3];

  logic        in_ready_a, out_valid_a, sign_a, ovf_a;
  logic [19:0] bcd_a;
  logic [4:0]  nz_a;
  logic        in_ready_b, out_valid_b, sign_b, ovf_b;
  logic [15:0] bcd_b;
  logic [3:0]  nz_b;
  logic        in_ready_c, out_valid_c, sign_c, ovf_c;
  logic [11:0] bcd_c;
  logic [2:0]  nz_c;

  int checks;
  int errors;

  bcd_dabble_conv #(.DATA_W(16), .DIGITS(5), .SIGNED(0)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_a), .data(data_s[0]),
    .out_valid(out_valid_a), .out_ready(out_ready_s[0]),
    .bcd(bcd_a), .sign(sign_a), .ovf(ovf_a), .nz_mask(nz_a)
  );

  bcd_dabble_conv #(.DATA_W(16), .DIGITS(4), .SIGNED(0)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_b), .data(data_s[1]),
    .out_valid(out_valid_b), .out_ready(out_ready_s[1]),
    .bcd(bcd_b), .sign(sign_b), .ovf(ovf_b), .nz_mask(nz_b)
  );

  bcd_dabble_conv #(.DATA_W(8), .DIGITS(3), .SIGNED(1)) u_dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_c), .data(data_s[2][7:0]),
    .out_valid(out_valid_c), .out_ready(out_ready_s[2]),
    .bcd(bcd_c), .sign(sign_c), .ovf(ovf_c), .nz_mask(nz_c)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] bcd_of(input int u);
    case (u)
      0:       return bcd_a;
      1:       return {4'h0, bcd_b};
      default: return {8'h00, bcd_c};
    endcase
  endfunction

  function automatic logic [4:0] nz_of(input int u);
    case (u)
      0:       return nz_a;
      1:       return {1'b0, nz_b};
      default: return {2'b00, nz_c};
    endcase
  endfunction

  function automatic logic ov_of(input int u);
    case (u)
      0:       return out_valid_a;
      1:       return out_valid_b;
      default: return out_valid_c;
    endcase
  endfunction

  function automatic logic ir_of(input int u);
    case (u)
      0:       return in_ready_a;
      1:       return in_ready_b;
      default: return in_ready_c;
    endcase
  endfunction

  function automatic logic ovf_of(input int u);
    case (u)
      0:       return ovf_a;
      1:       return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic logic sign_of(input int u);
    case (u)
      0:       return sign_a;
      1:       return sign_b;
      default: return sign_c;
    endcase
  endfunction

  // One full transaction on unit u: accept, wait for the result (bounded),
  // check it, optionally hold off the consumer for 'hold' cycles while offering
  // a competing input, then hand the result over.
  task automatic convert(input int u, input logic [15:0] d, input logic [19:0] exp_bcd,
                         input logic [4:0] exp_mask, input logic exp_ovf,
                         input logic exp_sign, input int hold);
    int n;
    int exp_lat;
    string tg;
    exp_lat = (u == 2) ? 9 : 17;
    tg = $sformatf("u%0d_d%0h", u, d);
    check({tg, "_in_ready_idle"}, 32'(ir_of(u)), 32'd1);
    in_valid_s[u] = 1'b1;
    data_s[u]     = d;
    @(posedge sys_clk);
    #1;
    in_valid_s[u] = 1'b0;
    n = 1;
    while (!ov_of(u) && n < 100) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check({tg, "_latency"}, 32'(n), 32'(exp_lat));
    check({tg, "_bcd"},     32'(bcd_of(u)), 32'(exp_bcd));
    check({tg, "_nz_mask"}, 32'(nz_of(u)), 32'(exp_mask));
    check({tg, "_ovf"},     32'(ovf_of(u)), 32'(exp_ovf));
    check({tg, "_sign"},    32'(sign_of(u)), 32'(exp_sign));
    check({tg, "_in_ready_busy"}, 32'(ir_of(u)), 32'd0);
    for (int k = 0; k < hold; k++) begin
      in_valid_s[u] = 1'b1;
      data_s[u]     = 16'h1111;
      @(posedge sys_clk);
      #1;
      check({tg, "_hold_valid"}, 32'(ov_of(u)), 32'd1);
      check({tg, "_hold_ready"}, 32'(ir_of(u)), 32'd0);
      check({tg, "_hold_bcd"},   32'(bcd_of(u)), 32'(exp_bcd));
      check({tg, "_hold_mask"},  32'(nz_of(u)), 32'(exp_mask));
    end
    in_valid_s[u]  = 1'b0;
    out_ready_s[u] = 1'b1;
    @(posedge sys_clk);
    #1;
    out_ready_s[u] = 1'b0;
    check({tg, "_post_valid"}, 32'(ov_of(u)), 32'd0);
    check({tg, "_post_ready"}, 32'(ir_of(u)), 32'd1);
    check({tg, "_post_bcd"},   32'(bcd_of(u)), 32'(exp_bcd));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      data_s[i]      = 16'h0000;
    end
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("u%0d_rst_in_ready", u),  32'(ir_of(u)), 32'd1);
      check($sformatf("u%0d_rst_out_valid", u), 32'(ov_of(u)), 32'd0);
      check($sformatf("u%0d_rst_bcd", u),       32'(bcd_of(u)), 32'd0);
      check($sformatf("u%0d_rst_nz", u),        32'(nz_of(u)), 32'd0);
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // out_ready while idle must not disturb anything.
    out_ready_s[0] = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    out_ready_s[0] = 1'b0;
    check("idle_out_ready_valid", 32'(out_valid_a), 32'd0);
    check("idle_out_ready_ready", 32'(in_ready_a), 32'd1);

    convert(0, 16'd1234,  20'h01234, 5'b01111, 1'b0, 1'b0, 0);
    convert(0, 16'd0,     20'h00000, 5'b00001, 1'b0, 1'b0, 0);
    convert(0, 16'd65535, 20'h65535, 5'b11111, 1'b0, 1'b0, 5);

    convert(1, 16'd12345, 20'h09999, 5'b01111, 1'b1, 1'b0, 0);
    convert(1, 16'd9999,  20'h09999, 5'b01111, 1'b0, 1'b0, 0);
    convert(1, 16'd7,     20'h00007, 5'b00001, 1'b0, 1'b0, 0);

    convert(2, 16'h0080, 20'h00128, 5'b00111, 1'b0, 1'b1, 0);
    convert(2, 16'h00FF, 20'h00001, 5'b00001, 1'b0, 1'b1, 0);
    convert(2, 16'h007F, 20'h00127, 5'b00111, 1'b0, 1'b0, 0);

    // Reset in the middle of a conversion; unit 0 still holds 65535 beforehand.
    in_valid_s[0] = 1'b1;
    data_s[0]     = 16'd1234;
    @(posedge sys_clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (8) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(in_ready_a), 32'd1);
    check("midrst_out_valid", 32'(out_valid_a), 32'd0);
    check("midrst_bcd",       32'(bcd_a), 32'd0);
    check("midrst_nz",        32'(nz_a), 32'd0);
    check("midrst_ovf_sign",  32'({ovf_a, sign_a}), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check("postrst_in_ready", 32'(in_ready_a), 32'd1);
    convert(0, 16'd42, 20'h00042, 5'b00011, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bcd_dabble_conv
